// File: rtl/alu_opcodes_pkg.sv
// ALU operation codes shared by the decode stage and the ALU.
// Register ops encode as {1'b0, funct7[5], funct3}; compares as {2'b10, funct3}.
package alu_opcodes_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_EQ   = 5'b10000;
    localparam logic [4:0] ALU_NE   = 5'b10001;
    localparam logic [4:0] ALU_LTS  = 5'b10100;
    localparam logic [4:0] ALU_GES  = 5'b10101;
    localparam logic [4:0] ALU_LTU  = 5'b10110;
    localparam logic [4:0] ALU_GEU  = 5'b10111;

endpackage

// File: rtl/decoder_pkg.sv
// RV32I major opcodes, operand/writeback select encodings and the decoded control bundle.
package decoder_pkg;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2
    } b_sel_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

    typedef struct packed {
        logic [4:0]  alu_op;
        a_sel_e      a_sel;
        b_sel_e      b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        gpr_we;
        wb_sel_e     wb_sel;
        logic        mem_req;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
    } decode_ctrl_t;

endpackage

// File: rtl/decoder_riscv.sv
// Combinational RV32I decoder: instruction word to control bundle.
// Illegal encodings (including any word whose low bits are not 2'b11) yield an all-zero bundle with illegal set.
module decoder_riscv
    import decoder_pkg::*;
    import alu_opcodes_pkg::*;
(
    input  logic [31:0]  instr,
    output decode_ctrl_t ctrl
);

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [31:0]  imm_i;
    logic [31:0]  imm_s;
    logic [31:0]  imm_b;
    logic [31:0]  imm_u;
    logic [31:0]  imm_j;
    logic         bad;
    decode_ctrl_t c;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        c   = '0;
        bad = 1'b0;
        case (opcode)
            OP: begin
                c.alu_op = {1'b0, funct7[5], funct3};
                c.rs1    = rs1;
                c.rs2    = rs2;
                c.rd     = rd;
                c.gpr_we = 1'b1;
                bad = !(funct7 == 7'b0000000 ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OP_IMM: begin
                // immediate ops never subtract; only the right shift honours funct7[5]
                c.alu_op = {2'b00, funct3};
                c.b_sel  = B_IMM;
                c.imm    = imm_i;
                c.rs1    = rs1;
                c.rd     = rd;
                c.gpr_we = 1'b1;
                if (funct3 == 3'b001) begin
                    bad = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    bad      = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
                    c.alu_op = {1'b0, funct7[5], funct3};
                end
            end
            LOAD: begin
                c.alu_op   = ALU_ADD;
                c.b_sel    = B_IMM;
                c.imm      = imm_i;
                c.rs1      = rs1;
                c.rd       = rd;
                c.gpr_we   = 1'b1;
                c.wb_sel   = WB_LOAD;
                c.mem_req  = 1'b1;
                c.mem_size = funct3;
                bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            STORE: begin
                c.alu_op   = ALU_ADD;
                c.b_sel    = B_IMM;
                c.imm      = imm_s;
                c.rs1      = rs1;
                c.rs2      = rs2;
                c.mem_req  = 1'b1;
                c.mem_we   = 1'b1;
                c.mem_size = funct3;
                bad = funct3[2] || (funct3[1:0] == 2'b11);
            end
            BRANCH: begin
                c.imm    = imm_b;
                c.rs1    = rs1;
                c.rs2    = rs2;
                c.branch = 1'b1;
                case (funct3)
                    3'b000:  c.alu_op = ALU_EQ;
                    3'b001:  c.alu_op = ALU_NE;
                    3'b100:  c.alu_op = ALU_LTS;
                    3'b101:  c.alu_op = ALU_GES;
                    3'b110:  c.alu_op = ALU_LTU;
                    3'b111:  c.alu_op = ALU_GEU;
                    default: bad = 1'b1;
                endcase
            end
            JAL: begin
                c.alu_op = ALU_ADD;
                c.a_sel  = A_PC;
                c.b_sel  = B_IMM;
                c.imm    = imm_j;
                c.rd     = rd;
                c.gpr_we = 1'b1;
                c.wb_sel = WB_PC4;
                c.jal    = 1'b1;
            end
            JALR: begin
                c.alu_op = ALU_ADD;
                c.b_sel  = B_IMM;
                c.imm    = imm_i;
                c.rs1    = rs1;
                c.rd     = rd;
                c.gpr_we = 1'b1;
                c.wb_sel = WB_PC4;
                c.jalr   = 1'b1;
                bad = (funct3 != 3'b000);
            end
            LUI: begin
                c.alu_op = ALU_ADD;
                c.a_sel  = A_ZERO;
                c.b_sel  = B_IMM;
                c.imm    = imm_u;
                c.rd     = rd;
                c.gpr_we = 1'b1;
            end
            AUIPC: begin
                c.alu_op = ALU_ADD;
                c.a_sel  = A_PC;
                c.b_sel  = B_IMM;
                c.imm    = imm_u;
                c.rd     = rd;
                c.gpr_we = 1'b1;
            end
            MISC_MEM, SYSTEM: begin
                c = '0;
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            c         = '0;
            c.illegal = 1'b1;
        end
        if (c.rd == 5'd0) begin
            c.gpr_we = 1'b0;
        end
    end

    assign ctrl = c;

endmodule

// File: rtl/decode_stage_riscv.sv
// RV32I decode stage: one-entry valid/ready pipeline register around the combinational decoder.
// Flush drops both the held bundle and any transfer offered in the same cycle.
module decode_stage_riscv
    import decoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [4:0]            alu_op_o,
    output logic [1:0]            a_sel_o,
    output logic [1:0]            b_sel_o,
    output logic [DATA_WIDTH-1:0] imm_o,
    output logic [4:0]            rs1_o,
    output logic [4:0]            rs2_o,
    output logic [4:0]            rd_o,
    output logic                  gpr_we_o,
    output logic [1:0]            wb_sel_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [2:0]            mem_size_o,
    output logic                  branch_o,
    output logic                  jal_o,
    output logic                  jalr_o,
    output logic                  illegal_o
);

    decode_ctrl_t          ctrl_d;
    decode_ctrl_t          ctrl_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  valid_q;
    logic                  accept;

    decoder_riscv u_decoder (
        .instr (instr_i),
        .ctrl  (ctrl_d)
    );

    assign in_ready_o = !valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign pc_o        = pc_q;
    assign alu_op_o    = ctrl_q.alu_op;
    assign a_sel_o     = ctrl_q.a_sel;
    assign b_sel_o     = ctrl_q.b_sel;
    assign imm_o       = ctrl_q.imm;
    assign rs1_o       = ctrl_q.rs1;
    assign rs2_o       = ctrl_q.rs2;
    assign rd_o        = ctrl_q.rd;
    assign gpr_we_o    = ctrl_q.gpr_we;
    assign wb_sel_o    = ctrl_q.wb_sel;
    assign mem_req_o   = ctrl_q.mem_req;
    assign mem_we_o    = ctrl_q.mem_we;
    assign mem_size_o  = ctrl_q.mem_size;
    assign branch_o    = ctrl_q.branch;
    assign jal_o       = ctrl_q.jal;
    assign jalr_o      = ctrl_q.jalr;
    assign illegal_o   = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage_riscv.sv
// Scoreboard bench for decode_stage_riscv: hand-decoded expectations queued on accept, compared on consume.
module tb_decode_stage_riscv;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  alu;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  wb;
        logic [4:0]  mem;   // {mem_req, mem_we, mem_size}
        logic [3:0]  xfer;  // {branch, jal, jalr, illegal}
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [31:0] pc;
    } sb_t;

    localparam int NV = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [4:0]  alu_op;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        gpr_we;
    logic [1:0]  wb_sel;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        illegal;

    int   n_vec;
    int   n_miss;
    logic acc;
    vec_t vecs [NV];
    sb_t  sb [$];

    decode_stage_riscv #(.DATA_WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .instr_i     (instr),
        .pc_i        (pc),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .pc_o        (pc_out),
        .alu_op_o    (alu_op),
        .a_sel_o     (a_sel),
        .b_sel_o     (b_sel),
        .imm_o       (imm),
        .rs1_o       (rs1),
        .rs2_o       (rs2),
        .rd_o        (rd),
        .gpr_we_o    (gpr_we),
        .wb_sel_o    (wb_sel),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_size_o  (mem_size),
        .branch_o    (branch),
        .jal_o       (jal),
        .jalr_o      (jalr),
        .illegal_o   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic [4:0] alu, input logic [1:0] a,
                                input logic [1:0] b, input logic [31:0] im, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] d, input logic we,
                                input logic [1:0] wb, input logic [4:0] mem, input logic [3:0] xf);
        vec_t v;
        v.instr = i;  v.alu = alu; v.a = a;   v.b = b;   v.imm = im; v.rs1 = r1;
        v.rs2 = r2;   v.rd = d;    v.we = we; v.wb = wb; v.mem = mem; v.xfer = xf;
        return v;
    endfunction

    // Drive one cycle of inputs; at the falling edge score the transfers the next rising edge performs.
    task automatic step(input logic v, input vec_t vv, input logic [31:0] p,
                        input logic fl, input logic rdy);
        sb_t e;
        in_valid = v; instr = vv.instr; pc = p; flush = fl; out_ready = rdy;
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        check("in_ready", 32'(in_ready), 32'((sb.size() == 0) || rdy));
        if (out_valid && out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            check("pc", pc_out, e.pc);
            check("alu_op", 32'(alu_op), 32'(e.v.alu));
            check("a_sel", 32'(a_sel), 32'(e.v.a));
            check("b_sel", 32'(b_sel), 32'(e.v.b));
            check("imm", imm, e.v.imm);
            check("regs", 32'({rs1, rs2, rd}), 32'({e.v.rs1, e.v.rs2, e.v.rd}));
            check("gpr_we", 32'(gpr_we), 32'(e.v.we));
            check("wb_sel", 32'(wb_sel), 32'(e.v.wb));
            check("mem", 32'({mem_req, mem_we, mem_size}), 32'(e.v.mem));
            check("xfer", 32'({branch, jal, jalr, illegal}), 32'(e.v.xfer));
        end
        acc = in_valid && in_ready && !flush;
        if (flush) begin
            sb.delete();
        end else if (acc) begin
            e.v  = vv;
            e.pc = p;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int first, input int last, input logic rdy);
        int i;
        int budget;
        i = first;
        budget = 0;
        while (i <= last && budget < 200) begin
            step(1'b1, vecs[i], 32'h1000 + 32'(i) * 4, 1'b0, rdy);
            if (acc) i++;
            budget++;
        end
        if (i <= last) check("stream_timeout", 32'(i), 32'(last + 1));
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        acc = 1'b0;
        vecs[0]  = mk(32'h00500093, 5'd0,  2'd0, 2'd1, 32'd5,        5'd0, 5'd0, 5'd1, 1'b1, 2'd0, 5'b00000, 4'b0000);
        vecs[1]  = mk(32'h402081B3, 5'd8,  2'd0, 2'd0, 32'd0,        5'd1, 5'd2, 5'd3, 1'b1, 2'd0, 5'b00000, 4'b0000);
        vecs[2]  = mk(32'h00208463, 5'd16, 2'd0, 2'd0, 32'd8,        5'd1, 5'd2, 5'd0, 1'b0, 2'd0, 5'b00000, 4'b1000);
        vecs[3]  = mk(32'hFFC12283, 5'd0,  2'd0, 2'd1, 32'hFFFFFFFC, 5'd2, 5'd0, 5'd5, 1'b1, 2'd1, 5'b10010, 4'b0000);
        vecs[4]  = mk(32'h00000000, 5'd0,  2'd0, 2'd0, 32'd0,        5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 5'b00000, 4'b0001);
        vecs[5]  = mk(32'h00100013, 5'd0,  2'd0, 2'd1, 32'd1,        5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 5'b00000, 4'b0000);
        vecs[6]  = mk(32'h00512423, 5'd0,  2'd0, 2'd1, 32'd8,        5'd2, 5'd5, 5'd0, 1'b0, 2'd0, 5'b11010, 4'b0000);
        vecs[7]  = mk(32'hFFDFF0EF, 5'd0,  2'd1, 2'd1, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd1, 1'b1, 2'd2, 5'b00000, 4'b0100);
        vecs[8]  = mk(32'h00008067, 5'd0,  2'd0, 2'd1, 32'd0,        5'd1, 5'd0, 5'd0, 1'b0, 2'd2, 5'b00000, 4'b0010);
        vecs[9]  = mk(32'h12345137, 5'd0,  2'd2, 2'd1, 32'h12345000, 5'd0, 5'd0, 5'd2, 1'b1, 2'd0, 5'b00000, 4'b0000);
        vecs[10] = mk(32'h00001197, 5'd0,  2'd1, 2'd1, 32'h00001000, 5'd0, 5'd0, 5'd3, 1'b1, 2'd0, 5'b00000, 4'b0000);
        vecs[11] = mk(32'h4030D213, 5'd13, 2'd0, 2'd1, 32'h00000403, 5'd1, 5'd0, 5'd4, 1'b1, 2'd0, 5'b00000, 4'b0000);
        vecs[12] = mk(32'h02309093, 5'd0,  2'd0, 2'd0, 32'd0,        5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 5'b00000, 4'b0001);
        vecs[13] = mk(32'h00500091, 5'd0,  2'd0, 2'd0, 32'd0,        5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 5'b00000, 4'b0001);
        vecs[14] = mk(32'h0FF0000F, 5'd0,  2'd0, 2'd0, 32'd0,        5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 5'b00000, 4'b0000);
        vecs[15] = mk(32'h007362B3, 5'd6,  2'd0, 2'd0, 32'd0,        5'd6, 5'd7, 5'd5, 1'b1, 2'd0, 5'b00000, 4'b0000);

        rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_bundle", 32'({alu_op, a_sel, b_sel, gpr_we, mem_req, illegal}), 32'd0);
        check("rst_imm", imm, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // full-throughput stream of every decode vector
        stream(0, NV - 1, 1'b1);
        step(1'b0, vecs[0], 32'd0, 1'b0, 1'b1);
        step(1'b0, vecs[0], 32'd0, 1'b0, 1'b1);

        // backpressure: hold addi for three cycles while sub waits at the input
        step(1'b1, vecs[0], 32'h2000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, vecs[1], 32'h2004, 1'b0, 1'b0);
            check("hold_accept", 32'(acc), 32'd0);
            check("hold_pc", pc_out, 32'h2000);
            check("hold_imm", imm, 32'd5);
            check("hold_rd", 32'(rd), 32'd1);
        end
        stream(1, 6, 1'b1);
        step(1'b0, vecs[0], 32'd0, 1'b0, 1'b1);

        // flush with a held bundle and a simultaneous incoming instruction
        step(1'b1, vecs[2], 32'h3000, 1'b0, 1'b0);
        step(1'b1, vecs[3], 32'h3004, 1'b1, 1'b0);
        step(1'b0, vecs[0], 32'd0, 1'b0, 1'b1);
        check("flush_valid", 32'(out_valid), 32'd0);

        // asynchronous reset in the middle of a held transfer
        step(1'b1, vecs[7], 32'h4000, 1'b0, 1'b0);
        in_valid = 1'b1; instr = vecs[8].instr; pc = 32'h4004;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_pc", pc_out, 32'd0);
        check("arst_imm", imm, 32'd0);
        check("arst_ctrl", 32'({alu_op, a_sel, b_sel, rd, gpr_we, wb_sel, jal}), 32'd0);
        sb.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // recovery after reset
        stream(9, 11, 1'b1);
        step(1'b0, vecs[0], 32'd0, 1'b0, 1'b1);
        step(1'b0, vecs[0], 32'd0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
